pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 96, width of the datapath payload (PC, operands, immediates).
REQ-002 Parameter CTRL_W, default 20, width of the control payload (RegWrite, MemRead, MemWrite, ALUOp, ...).
REQ-003 Parameter CNT_W, default 16, width of each performance counter.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream stage presents a beat.
REQ-007 in_ready  output  1  block can accept a beat this cycle.
REQ-008 in_data  input  DATA_W  upstream datapath payload.
REQ-009 in_ctrl  input  CTRL_W  upstream control payload.
REQ-010 flush  input  1  kill all held and incoming beats (branch or exception).
REQ-011 out_valid  output  1  a beat is presented downstream.
REQ-012 out_ready  input  1  downstream accepts the presented beat.
REQ-013 out_data  output  DATA_W  presented datapath payload.
REQ-014 out_ctrl  output  CTRL_W  presented control payload; all-zero whenever out_valid=0.
REQ-015 cnt_clr  input  1  synchronous clear of both counters.
REQ-016 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.
REQ-017 bubble_cnt  output  CNT_W  cycles with out_valid=0 and out_ready=1.

Function
REQ-018 Storage SHALL be a main entry driving the outputs plus one skid entry, with occupancy states EMPTY, ONE and TWO.
REQ-019 A beat transfers in when in_valid=1 and in_ready=1; it transfers out when out_valid=1 and out_ready=1.
REQ-020 in_ready SHALL be a registered signal equal to 1 in EMPTY and ONE and 0 in TWO, so it has no combinational path from out_ready.
REQ-021 Transitions: EMPTY+in -> ONE; ONE+in without out -> TWO (beat to skid); ONE+out without in -> EMPTY; ONE+in+out -> ONE (new beat to main); TWO+out -> ONE (skid moves to main); other cases hold state.
REQ-022 Latency from in transfer to out_valid SHALL be 1 cycle from EMPTY, and throughput SHALL be one beat per cycle while out_ready=1.
REQ-023 Beats SHALL leave in arrival order; none is duplicated or dropped except by flush.
REQ-024 flush=1 SHALL set the next state to EMPTY, discard any beat transferring in that same cycle, and force in_ready=1 on the next cycle.
REQ-025 On flush, held data registers MAY retain stale values, but out_ctrl SHALL read zero on the next cycle (bubble insertion).
REQ-026 An out transfer coinciding with flush SHALL count as delivered.
REQ-027 Counters SHALL saturate at all-ones and not wrap; cnt_clr has priority over increment and zeroes the counters on the next cycle.
REQ-028 flush SHALL NOT affect the counters.

Reset
REQ-029 While rst=0: state EMPTY, in_ready=0, out_valid=0, out_data=0, out_ctrl=0, skid contents=0, stall_cnt=0, bubble_cnt=0.
REQ-030 in_ready SHALL rise on the first posedge after rst deasserts; reset mid-transfer abandons all beats.

Structure
REQ-031 Occupancy-state encoding and default parameter values SHALL live in the shared pipeline package (pipe_pkg).
REQ-032 The saturating counter SHALL be one sub-module, sat_counter, instantiated twice.
REQ-033 One instance SHALL replace each fixed-width inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB), with control fields concatenated into in_ctrl.

Verification
REQ-034 Reset then in_data=0x5 with in_valid=1 and out_ready=1 for 1 cycle -> out_valid=1 with out_data=0x5 on the next cycle, and stall_cnt=0.
REQ-035 Hold out_ready=0 and send beats A, B, C -> in_ready=0 after B; after out_ready=1 the outputs are A then B (C never accepted); stall_cnt counts the held cycles.
REQ-036 State TWO plus flush together with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and nothing emerges later.
REQ-037 With CNT_W=4, hold out_ready=0 for 20 cycles with a held beat -> stall_cnt=15; assert cnt_clr -> 0.
REQ-038 Random in_valid/out_ready for 10k cycles against a reference queue model -> in-order output with no loss or duplication, and in_ready never rises combinationally from out_ready.
REQ-039 Pull rst low while in state TWO -> all outputs go to zero asynchronously, before the next clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline inter-stage registers.
//   occ_e        : occupancy of a skid register (EMPTY / ONE / TWO beats held)
//   *_W_DEF      : default payload and counter widths used by pipe_skid_reg
// ---------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    localparam int DATA_W_DEF = 96;
    localparam int CTRL_W_DEF = 20;
    localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock, state updates on posedge
//   rst   : asynchronous active-low reset, clears the count
//   clr   : synchronous clear, wins over inc
//   inc   : count this cycle
//   cnt   : current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
// Valid/ready inter-stage pipeline register with one skid entry, so that
// in_ready is a flop and never depends combinationally on out_ready.
// Used for every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB); the stage's
// control fields are concatenated onto in_ctrl.
//   clk, rst             : clock, asynchronous active-low reset
//   in_valid/in_ready    : upstream handshake (in_ready registered)
//   in_data/in_ctrl      : upstream datapath / control payload
//   flush                : drop every held and incoming beat
//   out_valid/out_ready  : downstream handshake
//   out_data/out_ctrl    : presented payload (out_ctrl zero when not valid)
//   cnt_clr              : synchronous clear of both performance counters
//   stall_cnt            : cycles with out_valid=1, out_ready=0 (saturating)
//   bubble_cnt           : cycles with out_valid=0, out_ready=1 (saturating)
// ---------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    occ_e              state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

    logic out_valid_w;
    logic in_fire;
    logic out_fire;

    assign out_valid_w = (state_q != OCC_EMPTY);
    assign in_fire     = in_valid && in_ready_q;
    assign out_fire    = out_valid_w && out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        case (state_q)
            OCC_EMPTY: begin
                if (in_fire) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                    state_d     = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (in_fire && out_fire) begin
                    // Main drains while the new beat replaces it.
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end else if (in_fire) begin
                    // Downstream stalled: park the new beat in the skid slot.
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                    state_d     = OCC_TWO;
                end else if (out_fire) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                // in_ready is low here, so only the drain case matters.
                if (out_fire) begin
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                    state_d     = OCC_ONE;
                end
            end
            default: begin
                state_d = OCC_EMPTY;
            end
        endcase

        // Data registers may keep stale contents; state alone kills the beats.
        if (flush) begin
            state_d = OCC_EMPTY;
        end

        // Ready next cycle whenever the skid slot will be free.
        in_ready_d = (state_d != OCC_TWO);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= OCC_EMPTY;
            in_ready_q  <= 1'b0;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_w;
    assign out_data  = main_data_q;
    // Bubble insertion: control reads zero whenever nothing is presented.
    assign out_ctrl  = out_valid_w ? main_ctrl_q : '0;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (out_valid_w && !out_ready),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (!out_valid_w && out_ready),
        .cnt (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_reg
// Self-checking bench: directed scenarios plus random handshakes, all
// compared against a queue-based reference model of the register.
// ---------------------------------------------------------------------------
module tb_pipe_skid_reg;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int NW = 4;
    localparam int CNT_MAX = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          cnt_clr = 1'b0;
    logic [NW-1:0] stall_cnt;
    logic [NW-1:0] bubble_cnt;

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .cnt_clr    (cnt_clr),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    // Reference model: beats held, in order, as {ctrl, data}.
    logic [CW+DW-1:0] q[$];
    bit               m_rdy = 1'b0;
    int               m_stall = 0;
    int               m_bubble = 0;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", 64'(in_ready), 64'(m_rdy));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_data", 64'(out_data), 64'(q[0][DW-1:0]));
            chk("out_ctrl", 64'(out_ctrl), 64'(q[0][CW+DW-1:DW]));
        end else begin
            chk("out_ctrl_bubble", 64'(out_ctrl), 64'd0);
        end
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
    endtask

    // One clock cycle: drive at negedge, advance model, check at next negedge.
    task automatic step(input bit iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input bit ordy, input bit fl, input bit clr);
        logic ir_before;
        bit   have, in_acc, out_acc;
        ir_before = in_ready;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        cnt_clr   = clr;
        #1;
        chk("ready_no_comb", 64'(in_ready), 64'(ir_before));

        have    = (q.size() != 0);
        in_acc  = iv && m_rdy && !fl;
        out_acc = have && ordy;
        if (clr) begin
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            if (have && !ordy && m_stall < CNT_MAX) m_stall++;
            if (!have && ordy && m_bubble < CNT_MAX) m_bubble++;
        end
        if (out_acc) void'(q.pop_front());
        if (fl) q.delete();
        else if (in_acc) q.push_back({c, d});
        m_rdy = (q.size() < 2);

        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic model_reset();
        q.delete();
        m_rdy    = 1'b0;
        m_stall  = 0;
        m_bubble = 0;
    endtask

    initial begin
        bit ordy_bias;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        chk("rst_bubble", 64'(bubble_cnt), 64'd0);
        rst = 1'b1;
        model_reset();
        check_outputs();

        // First posedge after reset raises in_ready.
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("ready_after_rst", 64'(in_ready), 64'd1);

        // Single beat, one-cycle latency, no stall counted.
        step(1'b1, 32'h5, 8'h11, 1'b1, 1'b0, 1'b0);
        chk("lat1_valid", 64'(out_valid), 64'd1);
        chk("lat1_data", 64'(out_data), 64'h5);
        chk("lat1_stall", 64'(stall_cnt), 64'd0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Back-pressure: A, B accepted, C refused until drain.
        step(1'b1, 32'hA, 8'h0A, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB, 8'h0B, 1'b0, 1'b0, 1'b0);
        chk("full_not_ready", 64'(in_ready), 64'd0);
        step(1'b1, 32'hC, 8'h0C, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC, 8'h0C, 1'b0, 1'b0, 1'b0);
        chk("head_is_A", 64'(out_data), 64'hA);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("then_B", 64'(out_data), 64'hB);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Flush while full and with a beat offered.
        step(1'b1, 32'h21, 8'h21, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h22, 8'h22, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h23, 8'h23, 1'b0, 1'b1, 1'b0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ctrl", 64'(out_ctrl), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("flush_nothing_later", 64'(out_valid), 64'd0);

        // Stall counter saturation and clear.
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h77, 8'h77, 1'b0, 1'b0, 1'b0);
        repeat (20) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("stall_saturated", 64'(stall_cnt), 64'd15);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("stall_cleared", 64'(stall_cnt), 64'd0);

        // Asynchronous reset while holding two beats.
        step(1'b1, 32'h31, 8'h31, 1'b0, 1'b0, 1'b0);
        chk("two_held_ready", 64'(in_ready), 64'd0);
        #2 rst = 1'b0;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_data", 64'(out_data), 64'd0);
        chk("arst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("arst_stall", 64'(stall_cnt), 64'd0);
        chk("arst_bubble", 64'(bubble_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        check_outputs();

        // Random handshakes; out_ready bias changes in phases.
        ordy_bias = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ((i % 256) == 0) ordy_bias = ($urandom_range(0, 1) == 1);
            step($urandom_range(0, 3) != 0,
                 DW'($urandom), CW'($urandom),
                 ordy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 63) == 0,
                 $urandom_range(0, 127) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
